labsim2_3_decoder: RTL and testbench
====================================

LABSIM2_3_DECODER -- requirements
Module: labsim2_3

Interface
REQ-001 Parameter ACTIVE_LOW, default 0; 1 inverts every q bit, so the selected line is 0 and all others are 1.
REQ-002 Port clk  input  1  rising-edge clock; the only clock.
REQ-003 Port rst_n  input  1  reset, synchronous to clk, active-low.
REQ-004 Port da  input  3  select code, 0..7, sampled on the rising edge of clk.
REQ-005 Port q  output  8  registered one-hot decode of da; bit i corresponds to code i.

Function
REQ-006 At each rising clk edge with rst_n=1, q SHALL load the decode of da:
- bit da set, all other bits clear (ACTIVE_LOW=0);
- bitwise inverse of that pattern (ACTIVE_LOW=1).
REQ-007 Latency SHALL be one clock: a da value present at edge N appears on q immediately after edge N and holds until edge N+1.
REQ-008 q SHALL change only on a rising clk edge; da changes between edges SHALL have no effect on q.
REQ-009 Exactly one q bit SHALL be in the active state after every non-reset edge; no all-active or all-inactive code exists outside reset.
REQ-010 da held constant SHALL keep q constant with no glitches.
REQ-011 Consecutive da values SHALL each be honoured on their own edge; every code 0..7 is legal.
REQ-012 The 000->111 and 111->000 transitions SHALL need no special handling.
REQ-013 q SHALL be driven directly from flip-flops, with no combinational path from da to q.

Reset
REQ-014 While rst_n=0 at a rising clk edge, q SHALL load the all-inactive value: 8'h00 (ACTIVE_LOW=0) or 8'hFF (ACTIVE_LOW=1).
REQ-015 Reset SHALL take priority over decoding and SHALL have no asynchronous effect; asserting rst_n mid-operation clears q at the next edge only.
REQ-016 On the first edge with rst_n=1 after reset, q SHALL decode the da present at that edge.
REQ-017 Before the first clock edge q is undefined; no initial value is required.

Structure
REQ-018 A shared package labsim2_pkg SHALL hold:
- SEL_W=3;
- OUT_W=8;
- the reset/inactive constant;
- a function decode3to8(sel) returning the active-high one-hot byte.
REQ-019 Top-level structure:
- one combinational sub-module, dec3to8 (da -> active-high one-hot);
- polarity inversion from ACTIVE_LOW;
- the output register with synchronous reset.
REQ-020 The design SHALL be fully synthesizable, with no latches and no simulation-only constructs in the RTL.

Verification
REQ-021 Verification SHALL cover these directed scenarios:
- Reset: rst_n=0 for 2 edges, any da -> q=8'h00 (8'hFF with ACTIVE_LOW=1).
- Sweep: release reset, da 000,001,...,111, each held 100 cycles -> q 01,02,04,08,10,20,40,80, each one edge after the da change.
- Mid-cycle change: da=010 changed to 110 between edges -> q stays 8'h04 until the next edge, then 8'h40.
- Reset mid-operation: q=8'h20 (da=101), rst_n=0 for one edge -> q=8'h00 on that edge; rst_n=1 with da=101 -> q=8'h20 on the next edge.
- Polarity: ACTIVE_LOW=1, da=011 -> q=8'hF7; da=000 -> q=8'hFE.
- Wrap: da 111->000 on consecutive edges -> q 8'h80 then 8'h01; a one-hot check on every edge after reset passes.

Source files
------------

// File: rtl/labsim2_pkg.sv
`default_nettype none
// ============================================================================
// Package : labsim2_pkg
// Brief   : Widths, the inactive output value and the 3-to-8 decode helper
//           shared by the labsim2_3 decoder files.
// Revision: 1.0 - initial release
// ============================================================================
package labsim2_pkg;

   localparam int SEL_W = 3;
   localparam int OUT_W = 8;

   // Output value with no line active, expressed in active-high polarity.
   localparam logic [OUT_W-1:0] OUT_INACTIVE = '0;

   // Active-high one-hot decode: bit 'sel' set, every other bit clear.
   function automatic logic [OUT_W-1:0] decode3to8(input logic [SEL_W-1:0] sel);
      logic [OUT_W-1:0] res;
      res      = '0;
      res[sel] = 1'b1;
      return res;
   endfunction

endpackage : labsim2_pkg
`default_nettype wire

// File: rtl/labsim2_3_decoder_dec3to8.sv
`default_nettype none
// ============================================================================
// Module  : dec3to8
// Brief   : Purely combinational 3-to-8 active-high one-hot decoder.
// Revision: 1.0 - initial release
// ============================================================================
module dec3to8
   import labsim2_pkg::*;
(
   input  logic [SEL_W-1:0] sel_i,
   output logic [OUT_W-1:0] onehot_o
);

   // Decode the select code into its one-hot line.
   always_comb begin
      onehot_o = decode3to8(sel_i);
   end

endmodule : dec3to8
`default_nettype wire

// File: rtl/labsim2_3_decoder.sv
`default_nettype none
// ============================================================================
// Module  : labsim2_3_decoder
// Brief   : Registered 3-to-8 decoder with selectable output polarity and a
//           synchronous active-low reset that forces all lines inactive.
// Revision: 1.0 - initial release
// ============================================================================
module labsim2_3_decoder
   import labsim2_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b0
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEL_W-1:0] da,
   output logic [OUT_W-1:0] q
);

   logic [OUT_W-1:0] dec_onehot;
   logic [OUT_W-1:0] pol_onehot;
   logic [OUT_W-1:0] inactive_val;
   logic [OUT_W-1:0] q_d;
   logic [OUT_W-1:0] q_q;

   dec3to8 u_dec (
      .sel_i    (da),
      .onehot_o (dec_onehot)
   );

   // Polarity is fixed at elaboration, so the inversion is resolved statically.
   generate
      if (ACTIVE_LOW) begin : g_pol_low
         assign pol_onehot   = ~dec_onehot;
         assign inactive_val = ~OUT_INACTIVE;
      end else begin : g_pol_high
         assign pol_onehot   = dec_onehot;
         assign inactive_val = OUT_INACTIVE;
      end
   endgenerate

   // Next output value: reset wins over the decode.
   always_comb begin
      q_d = pol_onehot;
      if (!rst_n) begin
         q_d = inactive_val;
      end
   end

   // Output register; q comes straight from these flops.
   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;

endmodule : labsim2_3_decoder
`default_nettype wire

// File: tb/tb_labsim2_3_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_labsim2_3_decoder
// Brief   : Scoreboard bench for both output polarities of the decoder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_labsim2_3_decoder;

   logic       clk;
   logic       rst_n;
   logic [2:0] da;
   logic [7:0] q_hi;
   logic [7:0] q_lo;

   int checks   = 0;
   int failures = 0;
   bit running  = 1'b0;

   typedef struct {
      logic [7:0] exp_hi;
      logic [7:0] exp_lo;
      bit         in_rst;
   } exp_t;

   exp_t sb[$];

   labsim2_3_decoder #(.ACTIVE_LOW(1'b0)) u_dut_hi (
      .clk   (clk),
      .rst_n (rst_n),
      .da    (da),
      .q     (q_hi)
   );

   labsim2_3_decoder #(.ACTIVE_LOW(1'b1)) u_dut_lo (
      .clk   (clk),
      .rst_n (rst_n),
      .da    (da),
      .q     (q_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the line numbered by the code is active, nothing in reset.
   function automatic logic [7:0] ref_hi(input bit rst_act, input int code);
      if (rst_act) return 8'h00;
      return 8'(1 << code);
   endfunction

   // Expected value captured from the inputs seen at each rising edge.
   always @(posedge clk) begin
      if (running) begin
         exp_t e;
         e.in_rst = (rst_n == 1'b0);
         e.exp_hi = ref_hi(e.in_rst, int'(da));
         e.exp_lo = ~e.exp_hi;
         sb.push_back(e);
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: each edge produces a new output, compared half a cycle later.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("q_active_high", q_hi, e.exp_hi);
         check("q_active_low",  q_lo, e.exp_lo);
         if (!e.in_rst) begin
            checks++;
            if ($countones(q_hi) != 1 || $countones(~q_lo) != 1) begin
               failures++;
               $display("FAIL onehot: got hi=%02h lo=%02h expected single active line", q_hi, q_lo);
            end
         end
      end
   end

   task automatic drive(input bit r, input logic [2:0] d);
      @(negedge clk);
      rst_n = r;
      da    = d;
   endtask

   initial begin
      rst_n = 1'b0;
      da    = 3'($urandom_range(0, 7));
      running = 1'b1;

      // Reset held for two edges with arbitrary codes.
      drive(1'b0, 3'($urandom_range(0, 7)));
      drive(1'b0, 3'($urandom_range(0, 7)));

      // Sweep every code, each held for 100 cycles.
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 100; k++) drive(1'b1, 3'(c));
      end

      // Wrap 7 -> 0 on consecutive edges.
      drive(1'b1, 3'd7);
      drive(1'b1, 3'd0);

      // Mid-cycle change: the output must not follow da between edges.
      drive(1'b1, 3'd2);
      @(posedge clk);
      #2 da = 3'd6;
      #1;
      check("midcycle_hi", q_hi, 8'h04);
      check("midcycle_lo", q_lo, 8'hFB);

      // Reset in the middle of operation, then immediate resume.
      drive(1'b1, 3'd5);
      drive(1'b1, 3'd5);
      drive(1'b0, 3'd5);
      drive(1'b1, 3'd5);
      drive(1'b1, 3'd3);
      drive(1'b1, 3'd0);

      // Random codes with occasional reset pulses.
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 15) != 0), 3'($urandom_range(0, 7)));
      end

      // Let the last queued expectations drain.
      @(negedge clk);
      running = 1'b0;
      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_labsim2_3_decoder
`default_nettype wire
